// File: rtl/sec_ecc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sec_ecc_pkg                                                  |
// | Description : Shared types and helpers for the pipelined SEC/SECDED       |
// |               decoder: H-matrix column generator, size legality check,    |
// |               per-word status type. Macro SECDED_DED_EN adds the overall   |
// |               parity bit to the codeword.                                  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
package sec_ecc_pkg;

`ifdef SECDED_DED_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

  typedef struct packed {
    logic ce;
    logic ue;
  } ecc_status_t;

  // Column of data bit j: the j-th value (ascending) with at least two bits set.
  function automatic int unsigned hcol(input int unsigned j, input int unsigned chk_w);
    int unsigned seen;
    int unsigned res;
    int unsigned val;
    seen = 0;
    res  = 0;
    for (val = 3; (val < (32'd1 << chk_w)) && (res == 0); val++) begin
      if ($countones(val) >= 2) begin
        if (seen == j) res = val;
        seen++;
      end
    end
    return res;
  endfunction

  // A Hamming code with chk_w check bits covers at most 2**chk_w-chk_w-1 data bits.
  function automatic bit dims_legal(input int data_w, input int chk_w);
    return (data_w >= 1) && (data_w <= ((2 ** chk_w) - chk_w - 1));
  endfunction

endpackage
`default_nettype wire

// File: rtl/sec_syndrome_gen.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sec_syndrome_gen                                             |
// | Description : Combinational Hamming syndrome of one codeword laid out as   |
// |               {data, chk, [par]}. With SECDED_DED_EN also produces the     |
// |               overall parity error pe.                                     |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module sec_syndrome_gen
  import sec_ecc_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int CHK_W  = 8
) (
  input  logic [DATA_W+CHK_W+PAR_W-1:0] cw_i,
`ifdef SECDED_DED_EN
  output logic                          pe_o,
`endif
  output logic [CHK_W-1:0]              syn_o
);

  localparam int CW_W = DATA_W + CHK_W + PAR_W;

  logic [DATA_W-1:0] data;
  logic [CHK_W-1:0]  chk;
  logic [CHK_W-1:0]  contrib [DATA_W];

  assign data = cw_i[CW_W-1 -: DATA_W];
  assign chk  = cw_i[PAR_W +: CHK_W];

  // Each set data bit contributes its constant H column.
  for (genvar j = 0; j < DATA_W; j++) begin : g_col
    localparam logic [CHK_W-1:0] COL = CHK_W'(hcol(j, CHK_W));
    assign contrib[j] = data[j] ? COL : '0;
  end

  // Check bit k has column 1<<k, so the check field seeds the XOR tree directly.
  always_comb begin
    syn_o = chk;
    for (int j = 0; j < DATA_W; j++) begin
      syn_o = syn_o ^ contrib[j];
    end
  end

`ifdef SECDED_DED_EN
  assign pe_o = ^cw_i;
`endif

endmodule
`default_nettype wire

// File: rtl/sec_decoder_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : sec_decoder_pipe                                             |
// | Description : Two-stage valid/ready SEC decoder with per-word status and   |
// |               saturating corrected/uncorrectable counters. Define          |
// |               SECDED_DED_EN for the extra overall-parity (DED) bit.        |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module sec_decoder_pipe
  import sec_ecc_pkg::*;
#(
  parameter int DATA_W = 128,
  parameter int CHK_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [DATA_W+CHK_W+PAR_W-1:0] in_cw,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [DATA_W-1:0]             out_data,
  output logic                          out_ce,
  output logic                          out_ue,
  output logic [CHK_W-1:0]              out_syndrome,
  input  logic                          cnt_clr,
  output logic [CNT_W-1:0]              ce_cnt,
  output logic [CNT_W-1:0]              ue_cnt
);

  localparam int CW_W = DATA_W + CHK_W + PAR_W;

  if (!dims_legal(DATA_W, CHK_W)) begin : g_dims_illegal
    $error("sec_decoder_pipe: DATA_W too large for CHK_W check bits");
  end

  logic [CHK_W-1:0]  syn_d;
  logic              s1_v_q;
  logic [DATA_W-1:0] s1_data_q;
  logic [CHK_W-1:0]  s1_syn_q;
  logic              s2_adv;
  logic              s1_adv;
  logic [DATA_W-1:0] data_hit;
  logic [CHK_W-1:0]  chk_hit;
  logic [DATA_W-1:0] data_d;
  ecc_status_t       status_d;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  ecc_status_t       out_status_q;
  logic [CHK_W-1:0]  out_syn_q;
  logic [CNT_W-1:0]  ce_cnt_q, ce_cnt_d;
  logic [CNT_W-1:0]  ue_cnt_q, ue_cnt_d;

`ifdef SECDED_DED_EN
  logic pe_d;
  logic s1_pe_q;

  sec_syndrome_gen #(.DATA_W(DATA_W), .CHK_W(CHK_W)) u_syn (
    .cw_i  (in_cw),
    .pe_o  (pe_d),
    .syn_o (syn_d)
  );
`else
  sec_syndrome_gen #(.DATA_W(DATA_W), .CHK_W(CHK_W)) u_syn (
    .cw_i  (in_cw),
    .syn_o (syn_d)
  );
`endif

  assign s2_adv   = !out_valid_q || out_ready;
  assign s1_adv   = !s1_v_q || s2_adv;
  assign in_ready = s1_adv;

  // S1: capture data plus syndrome; the check bits live on only through the syndrome.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v_q    <= 1'b0;
      s1_data_q <= '0;
      s1_syn_q  <= '0;
`ifdef SECDED_DED_EN
      s1_pe_q   <= 1'b0;
`endif
    end else if (s1_adv) begin
      s1_v_q    <= in_valid;
      s1_data_q <= in_cw[CW_W-1 -: DATA_W];
      s1_syn_q  <= syn_d;
`ifdef SECDED_DED_EN
      s1_pe_q   <= pe_d;
`endif
    end
  end

  // Comparator bank: one-hot hit vector over data columns and check columns.
  for (genvar j = 0; j < DATA_W; j++) begin : g_data_cmp
    localparam logic [CHK_W-1:0] COL = CHK_W'(hcol(j, CHK_W));
    assign data_hit[j] = (s1_syn_q == COL);
  end

  for (genvar k = 0; k < CHK_W; k++) begin : g_chk_cmp
    localparam logic [CHK_W-1:0] COL = CHK_W'(1) << k;
    assign chk_hit[k] = (s1_syn_q == COL);
  end

  // Decode: flip the matched data bit, otherwise pass raw data and flag the status.
  always_comb begin
    data_d   = s1_data_q;
    status_d = '0;
`ifdef SECDED_DED_EN
    if (s1_syn_q == '0) begin
      status_d.ce = s1_pe_q;
    end else if (s1_pe_q && ((|data_hit) || (|chk_hit))) begin
      data_d      = s1_data_q ^ data_hit;
      status_d.ce = 1'b1;
    end else begin
      status_d.ue = 1'b1;
    end
`else
    if (s1_syn_q != '0) begin
      if ((|data_hit) || (|chk_hit)) begin
        data_d      = s1_data_q ^ data_hit;
        status_d.ce = 1'b1;
      end else begin
        status_d.ue = 1'b1;
      end
    end
`endif
  end

  // S2: output register, frozen while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_status_q <= '0;
      out_syn_q    <= '0;
    end else if (s2_adv) begin
      out_valid_q <= s1_v_q;
      if (s1_v_q) begin
        out_data_q   <= data_d;
        out_status_q <= status_d;
        out_syn_q    <= s1_syn_q;
      end
    end
  end

  // Counters count completed transfers only, stick at all-ones, clear wins.
  always_comb begin
    ce_cnt_d = ce_cnt_q;
    ue_cnt_d = ue_cnt_q;
    if (cnt_clr) begin
      ce_cnt_d = '0;
      ue_cnt_d = '0;
    end else if (out_valid_q && out_ready) begin
      if (out_status_q.ce && (ce_cnt_q != '1)) ce_cnt_d = ce_cnt_q + CNT_W'(1);
      if (out_status_q.ue && (ue_cnt_q != '1)) ue_cnt_d = ue_cnt_q + CNT_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      ce_cnt_q <= '0;
      ue_cnt_q <= '0;
    end else begin
      ce_cnt_q <= ce_cnt_d;
      ue_cnt_q <= ue_cnt_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_ce       = out_status_q.ce;
  assign out_ue       = out_status_q.ue;
  assign out_syndrome = out_syn_q;
  assign ce_cnt       = ce_cnt_q;
  assign ue_cnt       = ue_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_sec_decoder_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_sec_decoder_pipe                                          |
// | Description : Scoreboard bench for sec_decoder_pipe (DATA_W=128, CHK_W=8,  |
// |               CNT_W=4). Follows SECDED_DED_EN when it is defined.          |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_sec_decoder_pipe;

  localparam int DATA_W = 128;
  localparam int CHK_W  = 8;
  localparam int CNT_W  = 4;
`ifdef SECDED_DED_EN
  localparam int PW = 1;
`else
  localparam int PW = 0;
`endif
  localparam int CW_W = DATA_W + CHK_W + PW;
  localparam int DOFF = PW + CHK_W;
  localparam int CMAX = (1 << CNT_W) - 1;
  localparam logic [DATA_W-1:0] BASE = 128'h0123456789ABCDEF0123456789ABCDEF;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              ce;
    logic              ue;
    logic [CHK_W-1:0]  syn;
    int                acc;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [CW_W-1:0]   in_cw = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DATA_W-1:0] out_data;
  logic              out_ce;
  logic              out_ue;
  logic [CHK_W-1:0]  out_syndrome;
  logic              cnt_clr = 1'b0;
  logic [CNT_W-1:0]  ce_cnt;
  logic [CNT_W-1:0]  ue_cnt;

  sec_decoder_pipe #(.DATA_W(DATA_W), .CHK_W(CHK_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_cw(in_cw),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ce(out_ce), .out_ue(out_ue), .out_syndrome(out_syndrome),
    .cnt_clr(cnt_clr), .ce_cnt(ce_cnt), .ue_cnt(ue_cnt)
  );

  always #5 clk = ~clk;

  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   last_lo = -10;
  int   rdy_mode = 0;     // 0: always ready, 1: random, 2: driven by main
  exp_t cur_exp;
  exp_t sb[$];
  logic [CHK_W-1:0] col_tab [DATA_W];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic ck(input string nm, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, req, cyc);
  endtask

  // Column of any codeword position: parity bit has none, check k is 1<<k.
  function automatic logic [CHK_W-1:0] pos_col(input int p);
    if (p < PW) return '0;
    if (p < DOFF) return CHK_W'(1) << (p - PW);
    return col_tab[p - DOFF];
  endfunction

  function automatic logic [CW_W-1:0] enc(input logic [DATA_W-1:0] d);
    logic [CHK_W-1:0] c = '0;
    for (int j = 0; j < DATA_W; j++) if (d[j]) c = c ^ col_tab[j];
`ifdef SECDED_DED_EN
    return {d, c, ^{d, c}};
`else
    return {d, c};
`endif
  endfunction

  function automatic exp_t mk(input logic [DATA_W-1:0] d, input logic ce, input logic ue,
                              input logic [CHK_W-1:0] s);
    exp_t e;
    e.data = d; e.ce = ce; e.ue = ue; e.syn = s; e.acc = 0;
    return e;
  endfunction

  // Reference decode: syndrome from the columns of set bits, search for a matching position.
  function automatic exp_t model(input logic [CW_W-1:0] cw);
    logic [CHK_W-1:0] syn = '0;
    logic [CW_W-1:0]  fix = cw;
    logic             pe = ^cw;
    int               hit = -1;
    exp_t             e;
    for (int p = 0; p < CW_W; p++) if (cw[p]) syn = syn ^ pos_col(p);
    if (syn != '0)
      for (int p = PW; p < CW_W; p++) if (pos_col(p) == syn) hit = p;
    e = mk('0, 1'b0, 1'b0, syn);
`ifdef SECDED_DED_EN
    if (syn == '0) e.ce = pe;
    else if (pe && hit >= 0) begin fix[hit] = ~fix[hit]; e.ce = 1'b1; end
    else e.ue = 1'b1;
`else
    if (syn != '0) begin
      if (hit >= 0) begin fix[hit] = ~fix[hit]; e.ce = 1'b1; end
      else e.ue = 1'b1;
    end
`endif
    e.data = fix[CW_W-1 -: DATA_W];
    return e;
  endfunction

  function automatic logic [DATA_W-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Record the expectation of every accepted word.
  always @(negedge clk) begin : p_push
    exp_t e;
    if (!rst && in_valid && in_ready) begin
      e = cur_exp;
      e.acc = cyc;
      sb.push_back(e);
    end
  end

  // Monitor: compare outputs, stall stability and counters against the model.
  logic              held = 1'b0;
  logic [DATA_W-1:0] h_data;
  logic [CHK_W+1:0]  h_stat;
  int                m_ce = 0;
  int                m_ue = 0;
  always @(negedge clk) begin : p_mon
    exp_t e;
    logic inc_ce, inc_ue;
    if (rst) begin
      sb.delete();
      m_ce = 0; m_ue = 0; held = 1'b0;
    end else begin
      if (!out_ready) last_lo = cyc;
      if (held) begin
        ck("hold_valid", out_valid, 1'b1);
        ck("hold_data", out_data, h_data);
        ck("hold_status", {out_ce, out_ue, out_syndrome}, h_stat);
      end
      ck("ce_cnt", ce_cnt, m_ce);
      ck("ue_cnt", ue_cnt, m_ue);
      if (out_ready) ck("in_ready_when_out_ready", in_ready, 1'b1);
      inc_ce = 1'b0; inc_ue = 1'b0;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) ck("spurious_out_valid", out_valid, 1'b0);
        else begin
          e = sb.pop_front();
          ck("out_data", out_data, e.data);
          ck("out_ce", out_ce, e.ce);
          ck("out_ue", out_ue, e.ue);
          ck("out_syndrome", out_syndrome, e.syn);
          if (last_lo < e.acc) ck("latency", cyc - e.acc, 2);
          inc_ce = e.ce; inc_ue = e.ue;
        end
      end
      if (cnt_clr) begin
        m_ce = 0; m_ue = 0;
      end else begin
        if (inc_ce && m_ce != CMAX) m_ce++;
        if (inc_ue && m_ue != CMAX) m_ue++;
      end
      held   = out_valid && !out_ready;
      h_data = out_data;
      h_stat = {out_ce, out_ue, out_syndrome};
    end
  end

  // Consumer ready pattern.
  always @(posedge clk) begin
    #1;
    if (rdy_mode == 1) out_ready = ($urandom_range(0, 3) != 0);
    else if (rdy_mode == 0) out_ready = 1'b1;
  end

  task automatic send(input logic [CW_W-1:0] cw, input exp_t e);
    bit done = 1'b0;
    in_valid = 1'b1; in_cw = cw; cur_exp = e;
    for (int g = 0; g < 100 && !done; g++) begin
      @(negedge clk); done = in_ready;
      @(posedge clk); #1;
    end
    if (!done) ck("send_timeout", in_ready, 1'b1);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin : p_watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, sb=%0d", sb.size());
    $fatal(1);
  end

  initial begin : p_main
    logic [CW_W-1:0]   cw;
    logic [DATA_W-1:0] d;
    int                n, c0, p1, p2;
    n = 0;
    for (int v = 1; n < DATA_W; v++) begin
      if ($countones(v) >= 2) begin col_tab[n] = v[CHK_W-1:0]; n++; end
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    ck("rst_out_valid", out_valid, 1'b0);
    ck("rst_in_ready", in_ready, 1'b1);
    ck("rst_out_data", out_data, '0);
    ck("rst_status", {out_ce, out_ue, out_syndrome}, '0);
    ck("rst_counters", {ce_cnt, ue_cnt}, '0);
    @(posedge clk); #1;

    // Clean stream at full rate
    c0 = cyc;
    for (int i = 0; i < 8; i++) begin
      d = BASE ^ DATA_W'(i);
      send(enc(d), mk(d, 1'b0, 1'b0, 8'h00));
    end
    ck("throughput_8_words", cyc - c0, 8);
    idle(4);

    // Directed single and double errors
    cw = enc(BASE); cw[DOFF + 0] = ~cw[DOFF + 0];
    send(cw, mk(BASE, 1'b1, 1'b0, 8'h03));
    cw = enc(BASE); cw[DOFF + 127] = ~cw[DOFF + 127];
    send(cw, mk(BASE, 1'b1, 1'b0, 8'h88));
    cw = enc(BASE); cw[PW + 5] = ~cw[PW + 5];
    send(cw, mk(BASE, 1'b1, 1'b0, 8'h20));
    cw = enc(BASE); cw[DOFF + 0] = ~cw[DOFF + 0]; cw[DOFF + 1] = ~cw[DOFF + 1];
`ifdef SECDED_DED_EN
    send(cw, mk(BASE ^ 128'h3, 1'b0, 1'b1, 8'h06));
    idle(4);
    ck("dir_ce_cnt", ce_cnt, 3);
    ck("dir_ue_cnt", ue_cnt, 1);
`else
    send(cw, mk(BASE ^ 128'h7, 1'b1, 1'b0, 8'h06));
    idle(4);
    ck("dir_ce_cnt", ce_cnt, 4);
    ck("dir_ue_cnt", ue_cnt, 0);
`endif

    // Backpressure: two accepts fill the pipe, then in_ready drops
    rdy_mode = 2;
    idle(1);
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      d = rnd_data(); cw = enc(d); send(cw, model(cw));
    end
    d = rnd_data(); cw = enc(d); cw[DOFF + 7] = ~cw[DOFF + 7];
    in_cw = cw; cur_exp = model(cw);
    repeat (3) begin
      @(negedge clk); ck("bp_in_ready", in_ready, 1'b0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    send(cw, model(cw));
    idle(5);
    rdy_mode = 0;

    // Saturation at CNT_W=4
    cnt_clr = 1'b1; idle(1); cnt_clr = 1'b0;
    for (int i = 0; i < 20; i++) begin
      d = rnd_data(); cw = enc(d);
      p1 = $urandom_range(DOFF, CW_W - 1); cw[p1] = ~cw[p1];
      send(cw, model(cw));
    end
    idle(5);
    ck("ce_cnt_saturated", ce_cnt, 15);

    // Clear in the same cycle as a corrected transfer
    d = rnd_data(); cw = enc(d); cw[DOFF + 9] = ~cw[DOFF + 9];
    send(cw, model(cw));
    in_valid = 1'b0;
    @(posedge clk); #1 cnt_clr = 1'b1;
    @(negedge clk); ck("clr_cycle_ce_word", {out_valid, out_ce}, 2'b11);
    @(posedge clk); #1 cnt_clr = 1'b0;
    @(negedge clk); ck("clr_wins", ce_cnt, 0);
    @(posedge clk); #1;

    // Randomized traffic with random backpressure
    rdy_mode = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      d = rnd_data(); cw = enc(d);
      case ($urandom_range(0, 3))
        1: begin p1 = $urandom_range(0, CW_W - 1); cw[p1] = ~cw[p1]; end
        2: begin
          p1 = $urandom_range(0, CW_W - 1);
          do p2 = $urandom_range(0, CW_W - 1); while (p2 == p1);
          cw[p1] = ~cw[p1]; cw[p2] = ~cw[p2];
        end
        3: for (int b = 0; b < CW_W; b += 32) cw = cw ^ (CW_W'($urandom) << b);
        default: ;
      endcase
      send(cw, model(cw));
    end
    in_valid = 1'b0;
    rdy_mode = 0;
    for (int g = 0; g < 60 && sb.size() != 0; g++) begin @(posedge clk); #1; end

    // Reset mid-stream drops words in flight
    for (int i = 0; i < 4; i++) begin
      d = rnd_data(); cw = enc(d); cw[DOFF + i] = ~cw[DOFF + i];
      send(cw, model(cw));
    end
    rst = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    ck("midrst_out_valid", out_valid, 1'b0);
    ck("midrst_in_ready", in_ready, 1'b1);
    ck("midrst_counters", {ce_cnt, ue_cnt}, '0);
    idle(6);
    ck("drain_pending_words", sb.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
